// File: rtl/load_req_buffer_pkg.sv
// load_req_buffer_pkg: shared load-buffer entry and state types
package load_req_buffer_pkg;
  localparam int TRANS_ID_W = 3;
  localparam int OFFSET_W   = 3;
  typedef struct packed {
    logic [TRANS_ID_W-1:0] trans_id;
    logic [OFFSET_W-1:0]   offset;
    logic [1:0]            size;
    logic                  sign_ext;
  } entry_t;
  typedef enum logic [1:0] {FREE = 2'd0, LIVE = 2'd1, FLUSHED = 2'd2} ldbuf_state_e;
endpackage

// File: rtl/load_req_buffer_lzc.sv
// load_req_buffer_lzc: trailing-zero counter, index of the lowest set bit
module load_req_buffer_lzc #(
  parameter int unsigned WIDTH = 2,
  localparam int unsigned CW = WIDTH > 1 ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CW-1:0]    cnt_o,
  output logic             empty_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) cnt_o = in_i[i] ? CW'(i) : cnt_o;
  end
  assign empty_o = ~|in_i;
endmodule

// File: rtl/load_req_buffer.sv
// load_req_buffer: tracks in-flight dcache loads, indexed by dcache request ID
module load_req_buffer
  import load_req_buffer_pkg::*;
#(
  parameter int unsigned NrEntries = 2,
  localparam int unsigned IdxWidth = NrEntries > 1 ? $clog2(NrEntries) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                alloc_valid_i,
  output logic                alloc_ready_o,
  output logic [IdxWidth-1:0] alloc_idx_o,
  input  entry_t              alloc_entry_i,
  input  logic                rsp_valid_i,
  input  logic [IdxWidth-1:0] rsp_idx_i,
  output logic                rsp_valid_o,
  output logic                rsp_drop_o,
  output entry_t              rsp_entry_o,
  output logic [IdxWidth:0]   count_o,
  output logic                err_o
);
  ldbuf_state_e state_q [NrEntries];
  ldbuf_state_e state_d [NrEntries];
  entry_t mem_q [NrEntries];
  logic [NrEntries-1:0] free;
  logic [IdxWidth:0] count_d;
  logic no_free, rsp_in, alloc_fire;
  ldbuf_state_e rsp_state;
  always_comb
    for (int i = 0; i < NrEntries; i++) free[i] = state_q[i] == FREE;
  load_req_buffer_lzc #(.WIDTH(NrEntries)) u_lzc (
    .in_i   (free),
    .cnt_o  (alloc_idx_o),
    .empty_o(no_free)
  );
  assign alloc_ready_o = ~no_free;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o && !flush_i;
  assign rsp_in        = 32'(rsp_idx_i) < NrEntries;
  assign rsp_state     = rsp_in ? state_q[rsp_idx_i] : FREE;
  assign rsp_entry_o   = rsp_in ? mem_q[rsp_idx_i] : '0;
  assign rsp_valid_o   = rsp_valid_i && rsp_state == LIVE;
  assign rsp_drop_o    = rsp_valid_i && rsp_state == FLUSHED;
  // flush, then response free, then alloc; alloc only targets FREE, response only non-FREE
  always_comb begin
    count_d = '0;
    for (int i = 0; i < NrEntries; i++) begin
      state_d[i] = state_q[i];
      state_d[i] = flush_i && state_q[i] == LIVE ? FLUSHED : state_d[i];
      state_d[i] = (rsp_valid_o || rsp_drop_o) && rsp_idx_i == IdxWidth'(i) ? FREE : state_d[i];
      state_d[i] = alloc_fire && alloc_idx_o == IdxWidth'(i) ? LIVE : state_d[i];
      count_d = count_d + (IdxWidth + 1)'(state_d[i] != FREE);
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NrEntries; i++) begin
        state_q[i] <= FREE;
        mem_q[i]   <= '0;
      end
      count_o <= '0;
      err_o   <= 1'b0;
    end else begin
      for (int i = 0; i < NrEntries; i++) state_q[i] <= state_d[i];
      if (alloc_fire) mem_q[alloc_idx_o] <= alloc_entry_i;
      count_o <= count_d;
      err_o   <= rsp_valid_i && rsp_state == FREE;
    end
  end
  a_count: assert property (@(posedge clk_i) disable iff (!rst_ni) count_o <= (IdxWidth + 1)'(NrEntries));
  a_alloc: assert property (@(posedge clk_i) disable iff (!rst_ni) alloc_fire |-> state_q[alloc_idx_o] == FREE);
  a_excl:  assert property (@(posedge clk_i) disable iff (!rst_ni) !(rsp_valid_o && rsp_drop_o));
endmodule

// File: tb/tb_load_req_buffer.sv
// tb_load_req_buffer: directed stimulus with a scoreboard-driven response monitor
module tb_load_req_buffer;
  import load_req_buffer_pkg::*;
  localparam int K_VALID = 0, K_DROP = 1, K_ERR = 2;
  typedef struct {int kind; entry_t e; string name;} sb_t;
  logic clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0, alloc_valid_i = 1'b0, rsp_valid_i = 1'b0;
  logic alloc_ready_o, rsp_valid_o, rsp_drop_o, err_o;
  logic [0:0] alloc_idx_o, rsp_idx_i = 1'b0;
  logic [1:0] count_o;
  entry_t alloc_entry_i = '0, rsp_entry_o;
  entry_t ea, eb, ec, ed, ee, ef, eg, eh;
  sb_t sb [$];
  int checks = 0, errors = 0;
  load_req_buffer #(.NrEntries(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o), .alloc_idx_o(alloc_idx_o),
    .alloc_entry_i(alloc_entry_i), .rsp_valid_i(rsp_valid_i), .rsp_idx_i(rsp_idx_i),
    .rsp_valid_o(rsp_valid_o), .rsp_drop_o(rsp_drop_o), .rsp_entry_o(rsp_entry_o),
    .count_o(count_o), .err_o(err_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic entry_t mk(int t, int o, int s, int g);
    entry_t e;
    e.trans_id = 3'(t);
    e.offset   = 3'(o);
    e.size     = 2'(s);
    e.sign_ext = 1'(g);
    return e;
  endfunction
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic expect_evt(int kind, entry_t e, string name);
    sb.push_back('{kind, e, name});
  endtask
  task automatic compare_evt(int kind, entry_t e);
    sb_t x;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d entry %h expected none", kind, e);
    end else begin
      x = sb.pop_front();
      if (x.kind != kind || (kind != K_ERR && x.e != e)) begin
        errors++;
        $display("FAIL %s: got kind %0d entry %h expected kind %0d entry %h", x.name, kind, e, x.kind, x.e);
      end
    end
  endtask
  always @(negedge clk_i) if (rst_ni) begin
    if (rsp_valid_o && rsp_drop_o) begin
      checks++;
      errors++;
      $display("FAIL rsp_excl: got valid=1 drop=1 expected at most one");
    end
    if (rsp_valid_o || rsp_drop_o) compare_evt(rsp_valid_o ? K_VALID : K_DROP, rsp_entry_o);
    if (err_o) compare_evt(K_ERR, '0);
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    ea = mk(5, 3, 2, 1); eb = mk(2, 5, 1, 0); ec = mk(7, 0, 3, 0); ed = mk(1, 1, 1, 1);
    ee = mk(6, 6, 2, 0); ef = mk(3, 2, 0, 1); eg = mk(4, 7, 3, 1); eh = mk(0, 4, 1, 0);
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_count", int'(count_o), 0);
    check("reset_ready", int'(alloc_ready_o), 1);
    check("reset_idx", int'(alloc_idx_o), 0);
    check("reset_outs", int'({rsp_valid_o, rsp_drop_o, err_o}), 0);
    check("reset_storage", int'(rsp_entry_o), 0);
    rst_ni = 1'b1;
    tick();
    // 1: first alloc
    alloc_valid_i = 1'b1; alloc_entry_i = ea;
    check("t1_idx", int'(alloc_idx_o), 0);
    tick();
    alloc_valid_i = 1'b0;
    check("t1_count", int'(count_o), 1);
    check("t1_next_idx", int'(alloc_idx_o), 1);
    // 2: fill, then live response on idx 1
    alloc_valid_i = 1'b1; alloc_entry_i = eb;
    tick();
    alloc_valid_i = 1'b0;
    check("t2_count_full", int'(count_o), 2);
    check("t2_ready_full", int'(alloc_ready_o), 0);
    rsp_valid_i = 1'b1; rsp_idx_i = 1'b1;
    expect_evt(K_VALID, eb, "t2_rsp_idx1");
    check("t2_ready_same_cycle", int'(alloc_ready_o), 0);
    tick();
    rsp_valid_i = 1'b0;
    check("t2_ready_next", int'(alloc_ready_o), 1);
    check("t2_idx_next", int'(alloc_idx_o), 1);
    check("t2_count_after", int'(count_o), 1);
    // 3: flush two live entries, both responses dropped
    alloc_valid_i = 1'b1; alloc_entry_i = ec;
    tick();
    alloc_valid_i = 1'b0; flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("t3_count_flushed", int'(count_o), 2);
    check("t3_ready_flushed", int'(alloc_ready_o), 0);
    rsp_valid_i = 1'b1; rsp_idx_i = 1'b0;
    expect_evt(K_DROP, ea, "t3_drop_idx0");
    tick();
    check("t3_count_1", int'(count_o), 1);
    check("t3_idx_reuse", int'(alloc_idx_o), 0);
    rsp_idx_i = 1'b1;
    expect_evt(K_DROP, ec, "t3_drop_idx1");
    tick();
    rsp_valid_i = 1'b0;
    check("t3_count_0", int'(count_o), 0);
    // 4: alloc during flush is discarded
    alloc_valid_i = 1'b1; alloc_entry_i = ed;
    tick();
    flush_i = 1'b1; alloc_entry_i = ee;
    check("t4_idx_before", int'(alloc_idx_o), 1);
    tick();
    flush_i = 1'b0; alloc_valid_i = 1'b0;
    check("t4_count", int'(count_o), 1);
    check("t4_ready", int'(alloc_ready_o), 1);
    check("t4_idx_after", int'(alloc_idx_o), 1);
    rsp_idx_i = 1'b1;
    check("t4_storage_untouched", int'(rsp_entry_o), int'(ec));
    rsp_valid_i = 1'b1; rsp_idx_i = 1'b0;
    expect_evt(K_DROP, ed, "t4_drop_idx0");
    tick();
    rsp_valid_i = 1'b0;
    check("t4_count_0", int'(count_o), 0);
    // 5: response to a free entry
    rsp_valid_i = 1'b1; rsp_idx_i = 1'b1;
    expect_evt(K_ERR, '0, "t5_err");
    tick();
    rsp_valid_i = 1'b0;
    check("t5_err_pulse", int'(err_o), 1);
    tick();
    check("t5_err_clear", int'(err_o), 0);
    check("t5_count", int'(count_o), 0);
    // 6: free and alloc in the same cycle, no bypass
    alloc_valid_i = 1'b1; alloc_entry_i = ef;
    tick();
    alloc_entry_i = eg;
    tick();
    alloc_entry_i = eh;
    check("t6_count_full", int'(count_o), 2);
    rsp_valid_i = 1'b1; rsp_idx_i = 1'b0;
    expect_evt(K_VALID, ef, "t6_rsp_idx0");
    check("t6_ready_same", int'(alloc_ready_o), 0);
    tick();
    rsp_valid_i = 1'b0;
    check("t6_ready_next", int'(alloc_ready_o), 1);
    check("t6_idx_next", int'(alloc_idx_o), 0);
    check("t6_count_mid", int'(count_o), 1);
    tick();
    alloc_valid_i = 1'b0;
    check("t6_count_back", int'(count_o), 2);
    rsp_idx_i = 1'b0;
    check("t6_storage_new", int'(rsp_entry_o), int'(eh));
    // async reset mid-cycle
    #2 rst_ni = 1'b0;
    #1;
    check("areset_count", int'(count_o), 0);
    check("areset_ready", int'(alloc_ready_o), 1);
    check("areset_storage", int'(rsp_entry_o), 0);
    tick();
    rst_ni = 1'b1;
    rsp_valid_i = 1'b1; rsp_idx_i = 1'b0;
    check("areset_no_valid", int'(rsp_valid_o), 0);
    expect_evt(K_ERR, '0, "areset_err");
    tick();
    rsp_valid_i = 1'b0;
    repeat (3) tick();
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
